mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle sequencing FSM for the ARM core. Steps each instruction through fetch, decode,
//  address, memory and writeback over one shared memory port, with a req/ack handshake.
//  Drives the datapath mux selects and the write strobes. Write strobes are gated by the
//  condition-check result. Sits beside the decoder; takes decoded fields from the latched instruction.
// PARAMETERS
//  none (encodings are fixed in mc_pkg)
// PORTS
//  clk         in   1  clock; single clock domain
//  reset_n     in   1  reset, synchronous, active-low
//  op          in   2  instr[27:26]
//  funct       in   6  instr[25:20]
//  rd          in   4  instr[15:12]
//  op2         in   2  instr[6:5]; a nonzero value with op==00 is a halfword/signed load/store
//  cond_ex     in   1  condition passes for the current instruction (stable from DECODE on)
//  mem_ack     in   1  memory completed the access this cycle (1-cycle pulse)
//  mem_req     out  1  memory access request
//  adr_src     out  1  0=PC, 1=ALU result
//  ir_write    out  1  latch instruction
//  pc_write    out  1  load PC from result bus
//  reg_w       out  1  register file write
//  mem_w       out  1  memory write (qualifies mem_req)
//  alu_src_a   out  1  0=Rn, 1=PC
//  alu_src_b   out  2  00=Rm/shifted, 01=ExtImm, 10=const 4
//  result_src  out  2  00=ALUOut reg, 01=read data, 10=ALU result
//  alu_op      out  1  1=DP instruction; ALU decoder uses funct
//  illegal     out  1  op==11 seen in DECODE (1-cycle pulse)
//  cycle_cnt   out  32 perf counter (MC_PERF_CNT_EN only, else 0)
//  instr_cnt   out  32 perf counter (MC_PERF_CNT_EN only, else 0)
// BEHAVIOUR
//  - Moore outputs are decoded from the registered state.
//  - While reset_n==0, the state register loads FETCH and every output is forced to 0.
//    mem_req rises in the first cycle after release.
//  - A reset during an outstanding access abandons it. A late mem_ack is ignored.
//  - FETCH: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10.
//    ir_write and pc_write = mem_ack. Hold until mem_ack, then -> DECODE.
//  - DECODE: alu_src_a=1, alu_src_b=10 (forms PC+8). Next state:
//      op==01, or op==00 with op2!=00   -> MEMADR
//      op==00, op2==00, funct[5]==0     -> EXECR
//      op==00, op2==00, funct[5]==1     -> EXECI
//      op==10                           -> BRANCH
//      op==11                           -> FETCH, with illegal=1
//  - MEMADR: alu_src_a=0. alu_src_b = imm_off ? 01 : 00.
//    imm_off = (op==01) ? ~funct[5] : funct[2]. Next state: funct[0] ? MEMRD : MEMWR.
//  - MEMRD: if ~cond_ex, go straight to FETCH with mem_req=0. Otherwise mem_req=1 and
//    adr_src=1; hold until mem_ack, then -> MEMWB.
//  - MEMWB: result_src=01, reg_w=1, pc_write=(rd==15) -> FETCH.
//  - MEMWR: if ~cond_ex, go straight to FETCH with mem_req=0. Otherwise mem_req=1, mem_w=1,
//    adr_src=1; hold until mem_ack, then -> FETCH.
//  - EXECR / EXECI: alu_src_a=0, alu_op=1, alu_src_b=00 / 01 -> ALUWB.
//  - ALUWB: result_src=00.
//    reg_w = cond_ex & ~(funct[4:3]==10); TST/TEQ/CMP/CMN do not write.
//    pc_write = reg_w & (rd==15). -> FETCH.
//  - BRANCH: alu_src_a=0, alu_src_b=01, result_src=10. pc_write=cond_ex.
//    reg_w = cond_ex & funct[4] (BL link write). -> FETCH.
//  - mem_ack is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
//    mem_req and mem_w stay stable until ack, with no unrequested retraction.
//  - Cycle counts with zero wait states:
//      DP = 4, LDR = 5, STR = 4, B = 3, illegal = 2.
//    Each wait state adds 1 cycle. A failed-condition load or store is 4 cycles.
// CONFIGURATION
//  - MC_PERF_CNT_EN defined:
//      cycle_cnt increments every cycle with reset_n==1.
//      instr_cnt increments on each transition into FETCH from a non-FETCH state.
//      Both wrap modulo 2^32 and are cleared by reset.
//  - MC_PERF_CNT_EN undefined: both ports are tied to 32'h0 and no counter flops exist.
// STRUCTURE
//  - mc_pkg holds:
//      typedef enum logic [3:0] mc_state_e {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
//        EXECR, EXECI, ALUWB, BRANCH}
//      localparams SRCB_REG/SRCB_IMM/SRCB_FOUR, RES_ALUOUT/RES_RDATA/RES_ALU
//  - One sub-module: mc_out_decode, a purely combinational state -> control-vector decoder.
//    The next-state logic and the counters stay in mc_controller.
// TESTING
//  1. Hold reset_n=0 3 cycles, mem_ack=1 -> all outputs 0.
//     Release -> mem_req=1, adr_src=0 next cycle.
//  2. ADD (op=00, funct=001000, rd=3), cond_ex=1, ack on first FETCH cycle
//     -> FETCH, DECODE, EXECR, ALUWB. reg_w=1 only in ALUWB, pc_write=0. instr_cnt +1.
//  3. LDR (op=01, funct=011001), mem_ack delayed 2 cycles in MEMRD
//     -> mem_req, adr_src=1 held 3 cycles. MEMWB result_src=01, reg_w=1. 7 cycles total.
//  4. STR with cond_ex=0 -> MEMADR -> FETCH; mem_req and mem_w never assert.
//     A stray mem_ack in DECODE is ignored.
//  5. BL (op=10, funct=010000), cond_ex=1 -> BRANCH: pc_write=1, reg_w=1.
//     With cond_ex=0 -> both 0 and back to FETCH.
//  6. reset_n=0 in MEMRD before ack -> FETCH next cycle, outputs 0, later ack ignored.
//     Plus op=11 -> illegal pulse, then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, mux-select constants and small decode helpers
// shared by the multicycle sequencer and its output decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } mc_state_e;

  // ALU operand B selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] RD_PC = 4'd15;

  // Word/byte transfers carry I in funct[5] (set = register offset);
  // halfword/signed transfers carry the immediate flag in funct[2].
  function automatic logic imm_off(input logic [1:0] op, input logic f5, input logic f2);
    return (op == 2'b01) ? ~f5 : f2;
  endfunction

  // TST/TEQ/CMP/CMN (opcode 10xx) only set flags.
  function automatic logic dp_writes(input logic [1:0] f43);
    return (f43 != 2'b10);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: purely combinational state -> control-vector decoder.
// Handshake-qualified strobes (ir_write/pc_write in FETCH) and condition-gated
// strobes are folded in here so the top only carries next-state and counters.
module mc_out_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic       cond_ex,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_w,
  output logic       mem_w,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       illegal
);

  logic w_unused_funct;
  logic w_dp_wr;

  assign w_unused_funct = &{1'b0, funct[1:0]};
  assign w_dp_wr        = cond_ex & dp_writes(funct[4:3]);

  // Decode control outputs from the current state
  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    alu_op     = 1'b0;
    illegal    = 1'b0;
    case (mc_state_e'(state))
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ack;
        pc_write   = mem_ack;
      end
      DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
        illegal   = (op == 2'b11);
      end
      MEMADR: begin
        alu_src_b = imm_off(op, funct[5], funct[2]) ? SRCB_IMM : SRCB_REG;
      end
      MEMRD: begin
        mem_req = cond_ex;
        adr_src = cond_ex;
      end
      MEMWB: begin
        result_src = RES_RDATA;
        reg_w      = 1'b1;
        pc_write   = (rd == RD_PC);
      end
      MEMWR: begin
        mem_req = cond_ex;
        mem_w   = cond_ex;
        adr_src = cond_ex;
      end
      EXECR: begin
        alu_op    = 1'b1;
        alu_src_b = SRCB_REG;
      end
      EXECI: begin
        alu_op    = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_w      = w_dp_wr;
        pc_write   = w_dp_wr & (rd == RD_PC);
      end
      BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = cond_ex;
        reg_w      = cond_ex & funct[4];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle sequencing FSM for the ARM core, one shared
// memory port with a req/ack handshake.
// Optional build macro: MC_PERF_CNT_EN adds 32-bit cycle/instruction counters;
// without it cycle_cnt/instr_cnt are tied to zero.
//
// state  | meaning
// FETCH  | request instruction word, latch IR and PC+4 on ack
// DECODE | form PC+8, dispatch on op/op2/funct
// MEMADR | compute load/store address
// MEMRD  | read access (skipped when condition fails)
// MEMWB  | write read data to Rd
// MEMWR  | write access (skipped when condition fails)
// EXECR  | data-processing, register operand
// EXECI  | data-processing, immediate operand
// ALUWB  | write ALU result unless compare/test
// BRANCH | PC <= target, optional link write
module mc_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rd,
  input  logic [1:0]  op2,
  input  logic        cond_ex,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_w,
  output logic        mem_w,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        alu_op,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  mc_state_e r_state;
  mc_state_e w_next;

  logic       w_mem_req;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_w;
  logic       w_mem_w;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_result_src;
  logic       w_alu_op;
  logic       w_illegal;

  // State register; reset drops any outstanding access and restarts at FETCH
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= FETCH;
    else          r_state <= w_next;
  end

  // Next-state: mem_ack only matters in the three access states
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  w_next = mem_ack ? DECODE : FETCH;
      DECODE: begin
        case (op)
          2'b01:   w_next = MEMADR;
          2'b00: begin
            if (op2 != 2'b00) w_next = MEMADR;
            else if (funct[5]) w_next = EXECI;
            else               w_next = EXECR;
          end
          2'b10:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR: w_next = funct[0] ? MEMRD : MEMWR;
      MEMRD: begin
        if (!cond_ex)     w_next = FETCH;
        else if (mem_ack) w_next = MEMWB;
        else              w_next = MEMRD;
      end
      MEMWB:  w_next = FETCH;
      MEMWR: begin
        if (!cond_ex || mem_ack) w_next = FETCH;
        else                     w_next = MEMWR;
      end
      EXECR:  w_next = ALUWB;
      EXECI:  w_next = ALUWB;
      ALUWB:  w_next = FETCH;
      BRANCH: w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  mc_out_decode u_out_decode (
    .state      (r_state),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .cond_ex    (cond_ex),
    .mem_ack    (mem_ack),
    .mem_req    (w_mem_req),
    .adr_src    (w_adr_src),
    .ir_write   (w_ir_write),
    .pc_write   (w_pc_write),
    .reg_w      (w_reg_w),
    .mem_w      (w_mem_w),
    .alu_src_a  (w_alu_src_a),
    .alu_src_b  (w_alu_src_b),
    .result_src (w_result_src),
    .alu_op     (w_alu_op),
    .illegal    (w_illegal)
  );

  // Outputs are forced quiet for as long as reset is held
  always_comb begin
    mem_req    = reset_n & w_mem_req;
    adr_src    = reset_n & w_adr_src;
    ir_write   = reset_n & w_ir_write;
    pc_write   = reset_n & w_pc_write;
    reg_w      = reset_n & w_reg_w;
    mem_w      = reset_n & w_mem_w;
    alu_src_a  = reset_n & w_alu_src_a;
    alu_src_b  = reset_n ? w_alu_src_b  : 2'b00;
    result_src = reset_n ? w_result_src : 2'b00;
    alu_op     = reset_n & w_alu_op;
    illegal    = reset_n & w_illegal;
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;
  logic        w_instr_done;

  assign w_instr_done = (r_state != FETCH) && (w_next == FETCH);

  // Free-running perf counters, wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cycle_cnt <= 32'h0;
      r_instr_cnt <= 32'h0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_instr_done) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = reset_n ? r_cycle_cnt : 32'h0;
  assign instr_cnt = reset_n ? r_instr_cnt : 32'h0;
`else
  assign cycle_cnt = 32'h0;
  assign instr_cnt = 32'h0;
`endif

endmodule
